// File: rtl/double_edge_detect_pkg.sv
// Shared helpers for the any-edge detector and its synchronizer.
package double_edge_detect_pkg;

    // A change in either direction is one event; the direction is deliberately dropped.
    function automatic logic any_edge(input logic cur, input logic prev);
        return cur ^ prev;
    endfunction

endpackage

// File: rtl/double_edge_detect_sync_chain.sv
// N-flop input synchronizer with synchronous reset to 0; N=0 degenerates to a wire.
module sync_chain #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    if (N == 0) begin : g_wire
        // Clock and reset are not needed when the input is already synchronous.
        logic unused_clk_rst;
        assign unused_clk_rst = clk | reset;
        assign q_o = d_i;
    end else begin : g_flops
        logic [N-1:0] sync_q;
        logic [N:0]   chain_d;

        assign chain_d = {sync_q, d_i};

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= chain_d[N-1:0];
            end
        end

        assign q_o = sync_q[N-1];
    end

endmodule

// File: rtl/double_edge_detect.sv
// Any-edge detector: one registered, one-cycle pulse per change of the (optionally synchronized) input.
module double_edge_detect
    import double_edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int SYNC_STAGES_MAX = 4;

    if (SYNC_STAGES < 0 || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_range_err
        $error("double_edge_detect: SYNC_STAGES must be in 0..4");
    end

    logic in_s;
    logic in_q;
    logic in_d;
    logic out_q;
    logic out_d;

    sync_chain #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (in),
        .q_o  (in_s)
    );

    // in_q starts at 0, so a high level right after reset reads as a rising edge.
    assign in_d  = in_s;
    assign out_d = any_edge(in_s, in_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q  <= 1'b0;
            out_q <= 1'b0;
        end else begin
            in_q  <= in_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_double_edge_detect.sv
// Bench for double_edge_detect: SYNC_STAGES=0 and SYNC_STAGES=2 instances share one stimulus.
module tb_double_edge_detect;

    logic clk;
    logic reset;
    logic din;
    logic out0;
    logic out2;

    int n_checks;
    int n_errors;

    typedef struct {
        logic rst;
        logic in_v;
        logic exp0;
        logic exp2;
    } vec_t;

    vec_t vecs[$];

    double_edge_detect #(.SYNC_STAGES(0)) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .in   (din),
        .out  (out0)
    );

    double_edge_detect #(.SYNC_STAGES(2)) u_dut2 (
        .clk  (clk),
        .reset(reset),
        .in   (din),
        .out  (out2)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Drive on the falling edge, let one rising edge sample, observe at the next falling edge.
    task automatic step(input logic rst_v, input logic in_v);
        reset = rst_v;
        din   = in_v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic i, input logic e0, input logic e2);
        vec_t v;
        v.rst = r; v.in_v = i; v.exp0 = e0; v.exp2 = e2;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        int last_pulse;
        logic p_in;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        din   = 1'b0;

        // Table: out0 = in(t)^in(t-1); out2 = in(t-2)^in(t-3); reset zeroes history.
        add(1, 0, 0, 0);  // 0  reset
        add(0, 0, 0, 0);  // 1
        add(0, 1, 1, 0);  // 2  rise
        add(0, 1, 0, 0);  // 3
        add(0, 0, 1, 1);  // 4  fall; DUT2 shows rise from step 2
        add(0, 0, 0, 0);  // 5
        add(0, 1, 1, 1);  // 6
        add(0, 0, 1, 0);  // 7
        add(0, 1, 1, 1);  // 8
        add(0, 0, 1, 1);  // 9
        add(0, 0, 0, 1);  // 10
        add(0, 0, 0, 1);  // 11
        add(0, 0, 0, 0);  // 12
        add(1, 1, 0, 0);  // 13 reset with in high
        add(0, 1, 1, 0);  // 14 post-reset high reads as rise
        add(0, 1, 0, 0);  // 15
        add(0, 1, 0, 1);  // 16 DUT2 sees the post-reset rise
        add(0, 1, 0, 0);  // 17
        add(0, 1, 0, 0);  // 18
        add(1, 0, 0, 0);  // 19 fall and reset at the same edge
        add(0, 0, 0, 0);  // 20
        add(0, 0, 0, 0);  // 21
        add(0, 0, 0, 0);  // 22

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].in_v);
            check("tbl_out0", i, out0, vecs[i].exp0);
            check("tbl_out2", i, out2, vecs[i].exp2);
        end

        // Reset with in low: out stays 0 while in stays 0.
        step(1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            check("rst_quiet", i, out0, 1'b0);
        end

        // Toggle every cycle for 10 cycles: out held high, then drops one cycle after the last change.
        for (int i = 1; i <= 10; i++) begin
            step(0, logic'(i % 2));
            check("toggle", i, out0, 1'b1);
        end
        step(0, 0);
        check("toggle_end", 0, out0, 1'b0);

        // Post-reset high input: one pulse, then quiet.
        step(1, 1);
        step(0, 1);
        check("post_rst_hi", 0, out0, 1'b1);
        step(0, 1);
        check("post_rst_hi", 1, out0, 1'b0);
        step(0, 1);
        check("post_rst_hi", 2, out0, 1'b0);

        // SYNC_STAGES=2 single rise: pulse visible on the third step counting the sampling step.
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        check("sync2_rise", 0, out2, 1'b0);
        step(0, 1);
        check("sync2_rise", 1, out2, 1'b0);
        step(0, 1);
        check("sync2_rise", 2, out2, 1'b1);
        step(0, 1);
        check("sync2_rise", 3, out2, 1'b0);
        step(0, 1);
        check("sync2_rise", 4, out2, 1'b0);

        // Periodic 2-high/6-low pattern over 1000 cycles: pulses at phase 0 and 2.
        step(1, 0);
        pulses     = 0;
        last_pulse = -1;
        p_in       = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            p_in = ((i % 8) < 2);
            step(0, p_in);
            check("periodic", i, out0, ((i % 8) == 0) || ((i % 8) == 2));
            if (out0 === 1'b1) begin
                if (last_pulse >= 0) begin
                    check("periodic_gap", i, (i - last_pulse == 2) || (i - last_pulse == 6), 1'b1);
                end
                last_pulse = i;
                pulses++;
            end
        end
        n_checks++;
        if (pulses != 250) begin
            n_errors++;
            $display("FAIL periodic_count: got %0d expected 250", pulses);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
